// File: rtl/brisc_pkg.sv
// Shared types for the brisc core: control bundle, immediate selectors,
// fetch queue entry and the main opcode decoder.
package brisc_pkg;

    localparam int ILEN     = 32;
    localparam int XLEN     = 32;
    localparam int REG_BITS = 5;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {I_IMM, S_IMM, B_IMM, J_IMM, U_IMM, NO_IMM} imm_src_e;
    typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_e;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        is_branch;
        logic        is_jump;
        alu_ctrl_e   alu_ctrl;
        logic        alu_src;
        logic [2:0]  mem_op_size;
        imm_src_e    imm_src;
        logic        xcpt;
    } ctrl_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fetch_entry_t;

    function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic ctrl_t ctrl_decode(input logic [ILEN-1:0] instr);
        ctrl_t c;
        c = '{reg_write: 1'b0, result_src: RES_ALU, mem_write: 1'b0, is_branch: 1'b0,
              is_jump: 1'b0, alu_ctrl: ALU_ADD, alu_src: 1'b0, mem_op_size: 3'd0,
              imm_src: NO_IMM, xcpt: 1'b0};
        case (instr[6:0])
            7'b0110011: begin
                c.reg_write = 1'b1;
                c.alu_ctrl  = alu_op(instr[14:12], instr[30]);
            end
            7'b0010011: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = I_IMM;
                // Only SRAI uses bit 30 as an opcode modifier; ADDI has no SUB form
                c.alu_ctrl  = alu_op(instr[14:12], (instr[14:12] == 3'd5) && instr[30]);
            end
            7'b0000011: begin
                c.reg_write   = 1'b1;
                c.result_src  = RES_MEM;
                c.alu_src     = 1'b1;
                c.imm_src     = I_IMM;
                c.mem_op_size = instr[14:12];
            end
            7'b0100011: begin
                c.mem_write   = 1'b1;
                c.alu_src     = 1'b1;
                c.imm_src     = S_IMM;
                c.mem_op_size = instr[14:12];
            end
            7'b1100011: begin
                c.is_branch = 1'b1;
                c.imm_src   = B_IMM;
                c.alu_ctrl  = ALU_SUB;
            end
            7'b1101111: begin
                c.reg_write  = 1'b1;
                c.is_jump    = 1'b1;
                c.result_src = RES_PC4;
                c.imm_src    = J_IMM;
            end
            7'b1100111: begin
                c.reg_write  = 1'b1;
                c.is_jump    = 1'b1;
                c.result_src = RES_PC4;
                c.alu_src    = 1'b1;
                c.imm_src    = I_IMM;
            end
            7'b0110111: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = U_IMM;
                c.alu_ctrl  = ALU_PASSB;
            end
            7'b0010111: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.imm_src   = U_IMM;
            end
            default: c.xcpt = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_queue_stage_imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate selected by imm_src.
module imm_gen
    import brisc_pkg::*;
(
    input  logic [ILEN-1:0] i_instr,
    input  imm_src_e        i_imm_src,
    output logic [XLEN-1:0] o_imm
);

    always_comb begin
        o_imm = '0;
        case (i_imm_src)
            I_IMM:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            S_IMM:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            B_IMM:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            J_IMM:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            U_IMM:   o_imm = {i_instr[31:12], 12'b0};
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Decode stage fed by a DEPTH-entry valid/ready instruction queue; the head
// entry is decoded combinationally with regfile read and WB write-through.
module decode_queue_stage
    import brisc_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush_in,
    input  logic                         valid_in,
    output logic                         ready_out,
    input  logic [ILEN-1:0]              instr_in,
    input  logic [XLEN-1:0]              pc_in,
    input  logic [XLEN-1:0]              pc_plus4_in,
    output logic                         valid_out,
    input  logic                         ready_in,
    input  logic [XLEN-1:0]              result_WB_in,
    input  logic [REG_BITS-1:0]          rd_WB_in,
    input  logic                         reg_write_WB_in,
    output logic [REG_BITS-1:0]          rd_out,
    output logic [REG_BITS-1:0]          rs1_out,
    output logic [REG_BITS-1:0]          rs2_out,
    output logic [XLEN-1:0]              pc_out,
    output logic [XLEN-1:0]              pc_plus4_out,
    output logic [XLEN-1:0]              rs1_data_out,
    output logic [XLEN-1:0]              rs2_data_out,
    output logic [XLEN-1:0]              imm_out,
    output logic                         reg_write_out,
    output result_src_e                  result_src_out,
    output logic                         mem_write_out,
    output logic                         is_branch_out,
    output logic                         is_jump_out,
    output alu_ctrl_e                    alu_ctrl_out,
    output logic                         alu_src_out,
    output logic [2:0]                   mem_op_size_out,
    output logic                         xcpt_out,
    output logic [$clog2(DEPTH+1)-1:0]   count_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_regs [32];

    logic         w_enq;
    logic         w_deq;
    logic         w_clear;
    fetch_entry_t w_head;
    ctrl_t        w_ctrl;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full queue refuses input even when it also dequeues this cycle
    assign ready_out = (r_count < CNT_W'(DEPTH));
    assign valid_out = (r_count != '0);
    assign count_out = r_count;
    assign w_clear   = reset | flush_in;
    assign w_enq     = valid_in & ready_out & ~w_clear;
    assign w_deq     = valid_out & ready_in;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= ptr_inc(r_tail);
            if (w_deq) r_head <= ptr_inc(r_head);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) r_mem[r_tail] <= '{instr: instr_in, pc: pc_in, pc_plus4: pc_plus4_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (reg_write_WB_in && (rd_WB_in != '0)) begin
            r_regs[rd_WB_in] <= result_WB_in;
        end
    end

    // Empty queue presents a NOP so every decoded field is benign
    always_comb begin
        w_head = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
        if (valid_out) w_head = r_mem[r_head];
    end

    assign w_ctrl       = ctrl_decode(w_head.instr);
    assign rd_out       = w_head.instr[11:7];
    assign rs1_out      = w_head.instr[19:15];
    assign rs2_out      = w_head.instr[24:20];
    assign pc_out       = w_head.pc;
    assign pc_plus4_out = w_head.pc_plus4;

    always_comb begin
        rs1_data_out = (rs1_out == '0) ? '0 : r_regs[rs1_out];
        rs2_data_out = (rs2_out == '0) ? '0 : r_regs[rs2_out];
        if (WB_BYPASS && reg_write_WB_in && (rd_WB_in != '0)) begin
            if (rd_WB_in == rs1_out) rs1_data_out = result_WB_in;
            if (rd_WB_in == rs2_out) rs2_data_out = result_WB_in;
        end
    end

    assign reg_write_out   = w_ctrl.reg_write & valid_out;
    assign result_src_out  = w_ctrl.result_src;
    assign mem_write_out   = w_ctrl.mem_write & valid_out;
    assign is_branch_out   = w_ctrl.is_branch & valid_out;
    assign is_jump_out     = w_ctrl.is_jump & valid_out;
    assign alu_ctrl_out    = w_ctrl.alu_ctrl;
    assign alu_src_out     = w_ctrl.alu_src;
    assign mem_op_size_out = w_ctrl.mem_op_size;
    assign xcpt_out        = w_ctrl.xcpt & valid_out;

    imm_gen u_imm_gen (
        .i_instr   (w_head.instr),
        .i_imm_src (w_ctrl.imm_src),
        .o_imm     (imm_out)
    );

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage (DEPTH=2, WB bypass on).
module tb_decode_queue_stage;
    import brisc_pkg::*;

    logic                clk = 1'b0;
    logic                reset, flush_in, valid_in, ready_in;
    logic [ILEN-1:0]     instr_in;
    logic [XLEN-1:0]     pc_in, pc_plus4_in, result_WB_in;
    logic [REG_BITS-1:0] rd_WB_in;
    logic                reg_write_WB_in;
    logic                ready_out, valid_out;
    logic [REG_BITS-1:0] rd_out, rs1_out, rs2_out;
    logic [XLEN-1:0]     pc_out, pc_plus4_out, rs1_data_out, rs2_data_out, imm_out;
    logic                reg_write_out, mem_write_out, is_branch_out, is_jump_out;
    logic                alu_src_out, xcpt_out;
    result_src_e         result_src_out;
    alu_ctrl_e           alu_ctrl_out;
    logic [2:0]          mem_op_size_out;
    logic [1:0]          count_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_queue_stage #(.DEPTH(2), .WB_BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .flush_in(flush_in), .valid_in(valid_in),
        .ready_out(ready_out), .instr_in(instr_in), .pc_in(pc_in),
        .pc_plus4_in(pc_plus4_in), .valid_out(valid_out), .ready_in(ready_in),
        .result_WB_in(result_WB_in), .rd_WB_in(rd_WB_in),
        .reg_write_WB_in(reg_write_WB_in), .rd_out(rd_out), .rs1_out(rs1_out),
        .rs2_out(rs2_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
        .reg_write_out(reg_write_out), .result_src_out(result_src_out),
        .mem_write_out(mem_write_out), .is_branch_out(is_branch_out),
        .is_jump_out(is_jump_out), .alu_ctrl_out(alu_ctrl_out),
        .alu_src_out(alu_src_out), .mem_op_size_out(mem_op_size_out),
        .xcpt_out(xcpt_out), .count_out(count_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        valid_in    = 1'b1;
        instr_in    = instr;
        pc_in       = pc;
        pc_plus4_in = pc + 32'd4;
        tick();
        valid_in = 1'b0;
        $display("push instr=%h pc=%h -> count=%0d ready=%0d", instr, pc, count_out, ready_out);
    endtask

    task automatic pop();
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        $display("pop -> count=%0d valid=%0d", count_out, valid_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        instr_in = '0; pc_in = '0; pc_plus4_in = '0;
        result_WB_in = '0; rd_WB_in = '0; reg_write_WB_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_imm", imm_out, 32'd0);
        chk("rst_regwr", 32'(reg_write_out), 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_xcpt", 32'(xcpt_out), 32'd0);

        // Fill under backpressure, then a refused third push
        push(32'h00500093, 32'h100);
        chk("fill1_count", 32'(count_out), 32'd1);
        chk("fill1_pc", pc_out, 32'h100);
        push(32'h00A00113, 32'h104);
        chk("full_count", 32'(count_out), 32'd2);
        chk("full_ready", 32'(ready_out), 32'd0);
        push(32'h00300193, 32'h108);
        chk("refuse_count", 32'(count_out), 32'd2);
        chk("hold_pc", pc_out, 32'h100);
        chk("hold_imm", imm_out, 32'd5);
        chk("hold_rd", 32'(rd_out), 32'd1);
        chk("hold_regwr", 32'(reg_write_out), 32'd1);
        chk("hold_pc4", pc_plus4_out, 32'h104);

        // Flush while full with a same-cycle push
        flush_in = 1'b1; valid_in = 1'b1; instr_in = 32'h00700213;
        pc_in = 32'h200; pc_plus4_in = 32'h204;
        tick();
        flush_in = 1'b0; valid_in = 1'b0;
        $display("flush -> count=%0d valid=%0d", count_out, valid_out);
        chk("flush_count", 32'(count_out), 32'd0);
        chk("flush_valid", 32'(valid_out), 32'd0);
        chk("flush_ready", 32'(ready_out), 32'd1);
        tick();
        chk("flush_drop_valid", 32'(valid_out), 32'd0);
        chk("flush_drop_pc", pc_out, 32'd0);

        // Streaming through pointer wrap: addi x(i+1), x0, i at pc 0x1000+4i
        ready_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_in    = 1'b1;
            instr_in    = {12'(i), 5'd0, 3'd0, 5'(i + 1), 7'h13};
            pc_in       = 32'h1000 + 32'(4 * i);
            pc_plus4_in = pc_in + 32'd4;
            tick();
            $display("stream %0d pc_out=%h imm=%0d count=%0d", i, pc_out, imm_out, count_out);
            chk($sformatf("stream%0d_pc", i), pc_out, 32'h1000 + 32'(4 * i));
            chk($sformatf("stream%0d_imm", i), imm_out, 32'(i));
            chk($sformatf("stream%0d_count", i), 32'(count_out), 32'd1);
        end
        valid_in = 1'b0;
        tick();
        ready_in = 1'b0;
        chk("drain_count", 32'(count_out), 32'd0);
        chk("drain_valid", 32'(valid_out), 32'd0);

        // add x3, x1, x2 with WB forwarding
        push(32'h002081B3, 32'h300);
        reg_write_WB_in = 1'b1; rd_WB_in = 5'd1; result_WB_in = 32'hDEADBEEF;
        #1;
        chk("byp_rs1", rs1_data_out, 32'hDEADBEEF);
        chk("byp_rs1_idx", 32'(rs1_out), 32'd1);
        chk("byp_rd", 32'(rd_out), 32'd3);
        tick();
        rd_WB_in = 5'd2; result_WB_in = 32'hCAFEF00D;
        #1;
        chk("byp_rs2", rs2_data_out, 32'hCAFEF00D);
        chk("rf_rs1", rs1_data_out, 32'hDEADBEEF);
        reg_write_WB_in = 1'b0;
        pop();

        // addi x2, x0, 0 with a WB write to x0
        push(32'h00000113, 32'h304);
        reg_write_WB_in = 1'b1; rd_WB_in = 5'd0; result_WB_in = 32'hFFFFFFFF;
        #1;
        chk("x0_rs1", rs1_data_out, 32'd0);
        chk("x0_rs1_idx", 32'(rs1_out), 32'd0);
        tick();
        reg_write_WB_in = 1'b0;
        chk("x0_after_write", rs1_data_out, 32'd0);
        pop();

        push(32'h123452B7, 32'h308);
        chk("lui_imm", imm_out, 32'h12345000);
        chk("lui_rd", 32'(rd_out), 32'd5);
        pop();

        push(32'hFFDFF0EF, 32'h30C);
        chk("jal_imm", imm_out, 32'hFFFFFFFC);
        chk("jal_jump", 32'(is_jump_out), 32'd1);
        pop();

        chk("ill_pre_xcpt", 32'(xcpt_out), 32'd0);
        push(32'h00000000, 32'h310);
        chk("ill_xcpt", 32'(xcpt_out), 32'd1);
        chk("ill_valid", 32'(valid_out), 32'd1);
        tick();
        chk("ill_hold_xcpt", 32'(xcpt_out), 32'd1);
        pop();
        chk("ill_post_xcpt", 32'(xcpt_out), 32'd0);
        chk("ill_post_valid", 32'(valid_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
